wb_adder_initiator: RTL and testbench

Wishbone classic bus initiator that drives the memory-mapped adder responder on behalf of local logic.
- Accepts an operand pair on a valid/ready command port.
- Runs the register sequence: write op1, write op2, set ctrl, poll status, read result, clear ctrl.
- Returns sum plus completion status on a valid/ready response port.
- Sits between a local control FSM/CPU-less datapath and the adder's Wishbone slave port, with the same address map and word addressing.

---
 rtl/wb_adder_pkg.sv | 32 +++
 rtl/wb_classic_xfer.sv | 70 +++++++
 rtl/wb_adder_initiator.sv | 161 ++++++++++++++++
 tb/tb_wb_adder_initiator.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_adder_pkg.sv
// Shared types and constants for the Wishbone adder initiator.
// Holds the sequencer states, the responder register map, ctrl values and response codes.
package wb_adder_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_OP1,
        S_WR_OP2,
        S_WR_CTRL,
        S_RD_STAT,
        S_RD_RES,
        S_WR_CLR,
        S_RSP
    } state_t;

    typedef enum logic [1:0] {
        RSP_OK      = 2'd0,
        RSP_BUS_ERR = 2'd1,
        RSP_TIMEOUT = 2'd2,
        RSP_POLL    = 2'd3
    } rsp_status_t;

    localparam int unsigned ADR_OP1  = 1;
    localparam int unsigned ADR_OP2  = 2;
    localparam int unsigned ADR_CTRL = 3;
    localparam int unsigned ADR_STAT = 4;
    localparam int unsigned ADR_RES  = 5;

    localparam int unsigned CTRL_GO  = 1;
    localparam int unsigned CTRL_CLR = 0;

endpackage

// File: rtl/wb_classic_xfer.sv
// Single Wishbone classic transfer engine: launches one request, holds the bus until
// ack/err or timeout, then drops everything for at least one idle cycle.
module wb_classic_xfer #(
    parameter int ADDR_WIDTH     = 3,
    parameter int DATA_WIDTH     = 32,
    parameter int SEL_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_adr,
    input  logic [DATA_WIDTH-1:0] req_dat,
    output logic                  done,
    output logic                  fail,
    output logic                  tmo,
    output logic                  cyc_o,
    output logic                  stb_o,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] adr_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic [SEL_WIDTH-1:0]  sel_o,
    input  logic                  ack_i,
    input  logic                  err_i
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic          active;
    logic [CW-1:0] cnt;

    assign cyc_o = active;
    assign stb_o = active;

    assign fail = active & err_i;
    assign done = active & ack_i & ~err_i;
    assign tmo  = active & ~ack_i & ~err_i & (cnt == CW'(TIMEOUT_CYCLES - 1));

    // A transfer can only start from the inactive branch, so the edge that ends one
    // transfer always leaves the bus low for a cycle before the next one starts.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active <= 1'b0;
            cnt    <= '0;
            we_o   <= 1'b0;
            adr_o  <= '0;
            dat_o  <= '0;
            sel_o  <= '0;
        end else if (active) begin
            if (ack_i || err_i || tmo) begin
                active <= 1'b0;
                we_o   <= 1'b0;
                adr_o  <= '0;
                dat_o  <= '0;
                sel_o  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else if (req) begin
            active <= 1'b1;
            cnt    <= '0;
            we_o   <= req_we;
            adr_o  <= req_adr;
            dat_o  <= req_dat;
            sel_o  <= '1;
        end
    end

endmodule

// File: rtl/wb_adder_initiator.sv
// Wishbone initiator for the memory-mapped adder: writes operands, starts the adder,
// polls status, reads the sum, clears ctrl and returns sum/status on a response port.
module wb_adder_initiator
    import wb_adder_pkg::*;
#(
    parameter int ADDR_WIDTH     = 3,
    parameter int DATA_WIDTH     = 32,
    parameter int GRANULE        = 8,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int POLL_MAX       = 8,
    localparam int SEL_WIDTH     = DATA_WIDTH / GRANULE
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [DATA_WIDTH-1:0] op_a_i,
    input  logic [DATA_WIDTH-1:0] op_b_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_sum_o,
    output logic [1:0]            rsp_status_o,
    output logic                  cyc_o,
    output logic                  stb_o,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] adr_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic [SEL_WIDTH-1:0]  sel_o,
    input  logic [DATA_WIDTH-1:0] dat_i,
    input  logic                  ack_i,
    input  logic                  err_i
);

    localparam int PW = $clog2(POLL_MAX + 1);

    state_t                state, state_nxt;
    rsp_status_t           status;
    logic [DATA_WIDTH-1:0] op_a, op_b, sum;
    logic [PW-1:0]         poll_cnt;
    logic                  poll_last;

    logic                  req, req_we, done, fail, tmo;
    logic [ADDR_WIDTH-1:0] req_adr;
    logic [DATA_WIDTH-1:0] req_dat;

    assign cmd_ready_o  = (state == S_IDLE);
    assign rsp_valid_o  = (state == S_RSP);
    assign rsp_sum_o    = sum;
    assign rsp_status_o = status;
    assign poll_last    = (poll_cnt == PW'(POLL_MAX - 1));

    wb_classic_xfer #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .DATA_WIDTH     (DATA_WIDTH),
        .SEL_WIDTH      (SEL_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_xfer (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req     (req),
        .req_we  (req_we),
        .req_adr (req_adr),
        .req_dat (req_dat),
        .done    (done),
        .fail    (fail),
        .tmo     (tmo),
        .cyc_o   (cyc_o),
        .stb_o   (stb_o),
        .we_o    (we_o),
        .adr_o   (adr_o),
        .dat_o   (dat_o),
        .sel_o   (sel_o),
        .ack_i   (ack_i),
        .err_i   (err_i)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        req_we    = 1'b0;
        req_adr   = '0;
        req_dat   = '0;
        case (state)
            S_IDLE: if (cmd_valid_i) state_nxt = S_WR_OP1;
            S_WR_OP1: begin
                req = 1'b1; req_we = 1'b1;
                req_adr = ADDR_WIDTH'(ADR_OP1); req_dat = op_a;
                if (done) state_nxt = S_WR_OP2;
            end
            S_WR_OP2: begin
                req = 1'b1; req_we = 1'b1;
                req_adr = ADDR_WIDTH'(ADR_OP2); req_dat = op_b;
                if (done) state_nxt = S_WR_CTRL;
            end
            S_WR_CTRL: begin
                req = 1'b1; req_we = 1'b1;
                req_adr = ADDR_WIDTH'(ADR_CTRL); req_dat = DATA_WIDTH'(CTRL_GO);
                if (done) state_nxt = S_RD_STAT;
            end
            S_RD_STAT: begin
                req = 1'b1;
                req_adr = ADDR_WIDTH'(ADR_STAT);
                if (done) begin
                    if (dat_i != '0)    state_nxt = S_RD_RES;
                    else if (poll_last) state_nxt = S_WR_CLR;
                end
            end
            S_RD_RES: begin
                req = 1'b1;
                req_adr = ADDR_WIDTH'(ADR_RES);
                if (done) state_nxt = S_WR_CLR;
            end
            S_WR_CLR: begin
                req = 1'b1; req_we = 1'b1;
                req_adr = ADDR_WIDTH'(ADR_CTRL); req_dat = DATA_WIDTH'(CTRL_CLR);
                if (done) state_nxt = S_RSP;
            end
            S_RSP: if (rsp_ready_i) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        // Bus error or timeout abandons the job, including the ctrl clear.
        if (fail || tmo) state_nxt = S_RSP;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_a     <= '0;
            op_b     <= '0;
            sum      <= '0;
            status   <= RSP_OK;
            poll_cnt <= '0;
        end else begin
            if (state == S_IDLE && cmd_valid_i) begin
                op_a     <= op_a_i;
                op_b     <= op_b_i;
                sum      <= '0;
                status   <= RSP_OK;
                poll_cnt <= '0;
            end
            if (fail) begin
                status <= RSP_BUS_ERR;
                sum    <= '0;
            end else if (tmo) begin
                status <= RSP_TIMEOUT;
                sum    <= '0;
            end else if (done) begin
                if (state == S_RD_STAT && dat_i == '0) begin
                    if (poll_last) status   <= RSP_POLL;
                    else           poll_cnt <= poll_cnt + 1'b1;
                end
                if (state == S_RD_RES) sum <= dat_i;
            end
        end
    end

endmodule

// File: tb/tb_wb_adder_initiator.sv
// Directed bench for wb_adder_initiator with a behavioural adder responder that can
// inject a bus error, hang a transfer, or return zero status a set number of times.
module tb_wb_adder_initiator;

    logic        clk, rst_n;
    logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [31:0] op_a, op_b, rsp_sum, dat_w, rdat;
    logic [1:0]  rsp_status;
    logic        cyc, stb, we, ack, err;
    logic [2:0]  adr;
    logic [3:0]  sel;

    logic [2:0]  err_adr, hang_adr;
    int          stat_zeros;

    logic [31:0] mem [8];
    logic        log_we [32];
    logic [2:0]  log_adr [32];
    logic [31:0] log_dat [32];
    int          n_xfer, n_rise, stb_hi, stat_reads, sel_bad, cyc_cnt;
    logic        stb_prev;
    int          total, bad;

    wb_adder_initiator #(
        .ADDR_WIDTH(3), .DATA_WIDTH(32), .GRANULE(8), .TIMEOUT_CYCLES(16), .POLL_MAX(8)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .op_a_i(op_a), .op_b_i(op_b),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_sum_o(rsp_sum), .rsp_status_o(rsp_status),
        .cyc_o(cyc), .stb_o(stb), .we_o(we), .adr_o(adr), .dat_o(dat_w), .sel_o(sel),
        .dat_i(rdat), .ack_i(ack), .err_i(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Responder with registered ack one cycle after stb, plus transfer monitor.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack <= 1'b0; err <= 1'b0; rdat <= '0; stb_prev <= 1'b0;
            stat_reads <= 0; n_xfer <= 0; n_rise <= 0; stb_hi <= 0; sel_bad <= 0;
        end else begin
            stb_prev <= stb;
            if (stb && !stb_prev) n_rise <= n_rise + 1;
            if (stb) stb_hi <= stb_hi + 1;
            if (stb && sel != 4'hF) sel_bad <= sel_bad + 1;
            if (cyc && stb && (ack || err)) begin
                if (n_xfer < 32) begin
                    log_we[n_xfer]  <= we;
                    log_adr[n_xfer] <= adr;
                    log_dat[n_xfer] <= dat_w;
                end
                n_xfer <= n_xfer + 1;
            end
            if (ack || err) begin
                ack <= 1'b0; err <= 1'b0;
            end else if (cyc && stb) begin
                if (we && adr == err_adr) err <= 1'b1;
                else if (adr != hang_adr) begin
                    ack <= 1'b1;
                    if (we) mem[adr] <= dat_w;
                    else if (adr == 3'd4) begin
                        rdat <= (stat_reads < stat_zeros) ? 32'd0 : 32'd1;
                        stat_reads <= stat_reads + 1;
                    end else if (adr == 3'd5) rdat <= mem[1] + mem[2];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_cmd(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_sum,
                           input logic [1:0] exp_st, input int hold, input int exp_lat);
        int t0;
        bit seen;
        @(negedge clk);
        chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; op_a = a; op_b = b;
        @(negedge clk);
        cmd_valid = 1'b0;
        t0 = cyc_cnt;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (rsp_valid) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        chk("rsp_seen", {31'd0, seen}, 32'd1);
        if (exp_lat >= 0) chk("latency", cyc_cnt - t0, exp_lat);
        chk("sum", rsp_sum, exp_sum);
        chk("status", {30'd0, rsp_status}, {30'd0, exp_st});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_sum", rsp_sum, exp_sum);
            chk("hold_status", {30'd0, rsp_status}, {30'd0, exp_st});
            chk("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("ready_after_rsp", {31'd0, cmd_ready}, 32'd1);
        chk("valid_after_rsp", {31'd0, rsp_valid}, 32'd0);
    endtask

    function automatic int count_adr(input logic [2:0] a);
        int n = 0;
        for (int i = 0; i < n_xfer && i < 32; i++) if (log_adr[i] == a) n++;
        return n;
    endfunction

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0; op_a = '0; op_b = '0;
        err_adr = 3'd0; hang_adr = 3'd0; stat_zeros = 0;
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_sum", rsp_sum, 32'd0);
        chk("rst_status", {30'd0, rsp_status}, 32'd0);
        chk("rst_bus", {26'd0, cyc, stb, we, adr}, 32'd0);
        chk("rst_dat", dat_w, 32'd0);
        chk("rst_sel", {28'd0, sel}, 32'd0);
        rst_n = 1'b1;

        // Basic add and exact bus sequence
        run_cmd(32'd5, 32'd7, 32'h0000_000C, 2'd0, 0, 18);
        chk("basic_nxfer", n_xfer, 32'd6);
        chk("basic_x0", {log_we[0], log_adr[0], log_dat[0][27:0]}, {1'b1, 3'd1, 28'd5});
        chk("basic_x1", {log_we[1], log_adr[1], log_dat[1][27:0]}, {1'b1, 3'd2, 28'd7});
        chk("basic_x2", {log_we[2], log_adr[2], log_dat[2][27:0]}, {1'b1, 3'd3, 28'd1});
        chk("basic_x3", {28'd0, log_we[3], log_adr[3]}, {28'd0, 1'b0, 3'd4});
        chk("basic_x4", {28'd0, log_we[4], log_adr[4]}, {28'd0, 1'b0, 3'd5});
        chk("basic_x5", {log_we[5], log_adr[5], log_dat[5][27:0]}, {1'b1, 3'd3, 28'd0});
        chk("basic_rises", n_rise, 32'd6);
        chk("basic_sel", sel_bad, 32'd0);

        // Wrap-around sum with a stalled consumer
        do_reset();
        run_cmd(32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 2'd0, 5, 18);

        // Two zero status reads before ready
        stat_zeros = 2;
        do_reset();
        run_cmd(32'd10, 32'd20, 32'd30, 2'd0, 0, 24);
        chk("poll_reads", count_adr(3'd4), 32'd3);
        chk("poll_nxfer", n_xfer, 32'd8);
        chk("poll_gaps", n_rise, 32'd8);

        // Status never ready: poll exhausted, ctrl still cleared
        stat_zeros = 1000;
        do_reset();
        run_cmd(32'd1, 32'd2, 32'd0, 2'd3, 0, 36);
        chk("exh_reads", count_adr(3'd4), 32'd8);
        chk("exh_nxfer", n_xfer, 32'd12);
        chk("exh_last", {log_we[11], log_adr[11], log_dat[11][27:0]}, {1'b1, 3'd3, 28'd0});
        stat_zeros = 0;

        // Bus error on the op2 write
        err_adr = 3'd2;
        do_reset();
        run_cmd(32'd1, 32'd2, 32'd0, 2'd1, 0, 6);
        repeat (5) @(negedge clk);
        chk("err_nxfer", n_xfer, 32'd2);
        chk("err_rises", n_rise, 32'd2);
        err_adr = 3'd0;

        // No ack on the op1 write, then a normal job
        hang_adr = 3'd1;
        do_reset();
        run_cmd(32'd5, 32'd7, 32'd0, 2'd2, 0, 17);
        chk("tmo_stb_hi", stb_hi, 32'd16);
        chk("tmo_nxfer", n_xfer, 32'd0);
        chk("tmo_rises", n_rise, 32'd1);
        hang_adr = 3'd0;
        run_cmd(32'd3, 32'd4, 32'd7, 2'd0, 0, 18);

        // Reset in the middle of the op2 write
        do_reset();
        begin
            bit found = 1'b0;
            @(negedge clk);
            cmd_valid = 1'b1; op_a = 32'd5; op_b = 32'd7;
            @(negedge clk);
            cmd_valid = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (stb && adr == 3'd2) begin found = 1'b1; break; end
                @(negedge clk);
            end
            chk("midrst_op2_seen", {31'd0, found}, 32'd1);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_cyc_stb", {30'd0, cyc, stb}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        repeat (25) @(negedge clk);
        chk("midrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_no_xfer", n_xfer, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
